mux_scan_n: RTL
===============

Name: mux_scan_n

Overview:
- Parametrised, registered N-channel word multiplexer; generalises the fixed 8:1 32-bit selector.
- Adds an auto-scan mode that rotates through enabled channels with a programmable dwell time. Target use is time-multiplexed display/debug readout of CPU registers and buses.
- Manual mode gives direct registered selection.
- Sits between datapath taps and the display/readout logic.

Parameters:
- WIDTH, 32, bits per channel word.
- NCH, 8, number of input channels (2..32).
- SELW, 3, select width; must satisfy 2^SELW >= NCH.
- DWELL_W, 16, width of the dwell counter/period input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel_in  input  SELW  manual channel index.
- din  input  NCH*WIDTH  flattened channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- ch_en  input  NCH  per-channel enable mask (auto mode only).
- dwell  input  DWELL_W  cycles spent on each channel in auto mode.
- hold  input  1  freezes scan pointer and dwell counter.
- dout  output  WIDTH  registered selected word.
- sel_out  output  SELW  index of channel currently driven on dout.
- valid  output  1  dout holds a legitimate channel word.
- wrap  output  1  one-cycle pulse when the scan pointer wraps.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - dout = 0, sel_out = 0, valid = 0, wrap = 0
  - dwell counter = 0, state = MANUAL
- All outputs are registered; they update together on the rising edge.
- dout always equals din[sel_out] as sampled on that same edge. Latency from the select decision to dout is 1 cycle.
- States:
  - MANUAL (mode = 0)
  - SCAN (mode = 1, ch_en != 0)
  - EMPTY (mode = 1, ch_en == 0)
- The state is re-evaluated every cycle from mode and ch_en.
- MANUAL:
  - Each edge: sel_out <= sel_in, dout <= din[sel_in], valid <= 1, wrap <= 0, dwell counter <= 0.
  - sel_in >= NCH: sel_out <= sel_in, dout <= 0, valid <= 0.
  - ch_en is ignored.
- SCAN:
  - The dwell counter increments each cycle.
  - When counter >= max(dwell,1)-1: counter <= 0 and the pointer advances to the next enabled channel, searching circularly upward from sel_out+1.
  - dwell = 0 behaves as dwell = 1, i.e. the pointer advances every cycle.
  - Otherwise the pointer stays and dout keeps refreshing from din[sel_out]; live data is tracked.
  - wrap <= 1 on the edge where the advance selects an index <= the old sel_out. This includes a single enabled channel re-selecting itself.
  - valid <= 1.
- Entry into SCAN, or sel_out not enabled (e.g. ch_en changed):
  - On the next edge the pointer moves to the next enabled channel at or after sel_out (circular).
  - The counter resets to 0.
  - wrap pulses if that move wraps.
- EMPTY: sel_out holds, dout <= 0, valid <= 0, wrap <= 0, counter <= 0.
- hold = 1 (SCAN only):
  - Counter and pointer freeze and wrap = 0.
  - dout still refreshes from din[sel_out].
  - The disabled-pointer correction is also deferred while hold = 1.
- Simultaneous mode change and dwell terminal: mode wins; the MANUAL rules apply on that edge.
- Mode 1 -> 0: the next edge takes sel_in immediately.
- Mode 0 -> 1: scanning starts from the last manual sel_out. If sel_out >= NCH, the search starts from index 0.
- A dwell change mid-period takes effect at the next comparison. If counter >= new dwell-1, the pointer advances on the next edge.
- Reset mid-scan restores the reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset/manual:
  - Stimulus: rst_n low, then high; mode = 0, sel_in = 5, din[5] = 32'hDEAD_BEEF.
  - Response: outputs are 0 during reset; 1 edge later dout = DEADBEEF, sel_out = 5, valid = 1.
- Manual out-of-range:
  - Stimulus: NCH = 6, SELW = 3, sel_in = 7.
  - Response: dout = 0, valid = 0, sel_out = 7.
- Auto scan with skip:
  - Stimulus: mode = 1, dwell = 3, ch_en = 8'b1010_0101, start sel_out = 0.
  - Response: sel_out sequence 0,0,0,2,2,2,5,5,5,7,7,7,0; wrap = 1 only on the 7 -> 0 edge.
- dwell = 0 / single channel:
  - Stimulus: ch_en = 8'b0001_0000, dwell = 0.
  - Response: sel_out stays 4 and wrap pulses every cycle.
  - Then set ch_en = 0: valid drops to 0 and dout = 0 on the next edge.
- Hold and live data:
  - Stimulus: scanning at channel 2, assert hold for 10 cycles while changing din[2] 1 -> 2 -> 3.
  - Response: sel_out stays 2, dout follows 1,2,3 with 1-cycle lag, wrap = 0, and the counter resumes from its frozen value.
- Async reset mid-scan:
  - Stimulus: pulse rst_n low between clock edges.
  - Response: outputs clear without a clock edge; after release with mode = 1 and ch_en = 8'hFF, sel_out steps 0,1,2... at the dwell rate.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel word multiplexer with manual select and an auto-scan
// mode that rotates through enabled channels at a programmable dwell rate.
module mux_scan_n #(
  parameter int WIDTH   = 32,
  parameter int NCH     = 8,
  parameter int SELW    = 3,
  parameter int DWELL_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel_in,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic [NCH-1:0]         ch_en,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   hold,
  output logic [WIDTH-1:0]       dout,
  output logic [SELW-1:0]        sel_out,
  output logic                   valid,
  output logic                   wrap
);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_EMPTY  = 2'd2;

  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic [WIDTH-1:0]   r_dout;
  logic [SELW-1:0]    r_sel;
  logic               r_valid;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic [1:0]         r_state;

  logic [1:0]         w_state;
  logic [SELW-1:0]    w_sel_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               w_valid_nxt;
  logic               w_wrap_nxt;
  logic [WIDTH-1:0]   w_dout_nxt;
  logic [DWELL_W-1:0] w_dwell_m1;
  logic               w_cur_in;
  logic               w_cur_en;
  logic [SELW-1:0]    w_start_adv;
  logic [SELW-1:0]    w_start_fix;
  logic [SELW-1:0]    w_found_adv;
  logic [SELW-1:0]    w_found_fix;

  // First enabled channel at or after start, searching circularly.
  function automatic logic [SELW-1:0] f_find(input logic [SELW-1:0] start,
                                             input logic [NCH-1:0] en);
    logic [SELW-1:0] res;
    logic            found;
    int              idx;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(start) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && en[idx]) begin
        res   = idx[SELW-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic f_en_at(input logic [SELW-1:0] sel,
                                   input logic [NCH-1:0] en);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel) == k) r = en[k];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] f_word(input logic [SELW-1:0] sel,
                                              input logic [NCH*WIDTH-1:0] d);
    logic [WIDTH-1:0] w;
    w = {WIDTH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel) == k) w = d[k*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  // Operating state follows mode and the enable mask every cycle.
  always_comb begin
    if (!mode) begin
      w_state = ST_MANUAL;
    end else if (ch_en == {NCH{1'b0}}) begin
      w_state = ST_EMPTY;
    end else begin
      w_state = ST_SCAN;
    end
  end

  assign w_dwell_m1  = (dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : dwell - DWELL_W'(1);
  assign w_cur_in    = ({1'b0, r_sel} < NCH_L);
  assign w_cur_en    = w_cur_in && f_en_at(r_sel, ch_en);
  assign w_start_adv = ({1'b0, r_sel} >= (NCH_L - (SELW+1)'(1))) ? {SELW{1'b0}} : r_sel + SELW'(1);
  assign w_start_fix = w_cur_in ? r_sel : {SELW{1'b0}};
  assign w_found_adv = f_find(w_start_adv, ch_en);
  assign w_found_fix = f_find(w_start_fix, ch_en);

  // Next pointer, counter and flags; a correction (entry or disabled pointer) outranks the dwell advance.
  always_comb begin
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_wrap_nxt  = 1'b0;
    case (w_state)
      ST_MANUAL: begin
        w_sel_nxt   = sel_in;
        w_cnt_nxt   = {DWELL_W{1'b0}};
        w_valid_nxt = ({1'b0, sel_in} < NCH_L);
      end
      ST_SCAN: begin
        if (hold) begin
          w_sel_nxt = r_sel;
        end else if ((r_state != ST_SCAN) || !w_cur_en) begin
          w_sel_nxt  = w_found_fix;
          w_cnt_nxt  = {DWELL_W{1'b0}};
          w_wrap_nxt = w_cur_in && (w_found_fix < r_sel);
        end else if (r_cnt >= w_dwell_m1) begin
          w_sel_nxt  = w_found_adv;
          w_cnt_nxt  = {DWELL_W{1'b0}};
          w_wrap_nxt = (w_found_adv <= r_sel);
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
        w_valid_nxt = ({1'b0, w_sel_nxt} < NCH_L);
      end
      ST_EMPTY: begin
        w_cnt_nxt = {DWELL_W{1'b0}};
      end
      default: begin
        w_sel_nxt = {SELW{1'b0}};
        w_cnt_nxt = {DWELL_W{1'b0}};
      end
    endcase
    w_dout_nxt = w_valid_nxt ? f_word(w_sel_nxt, din) : {WIDTH{1'b0}};
  end

  // Output and scan-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= {WIDTH{1'b0}};
      r_sel   <= {SELW{1'b0}};
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= {DWELL_W{1'b0}};
      r_state <= ST_MANUAL;
    end else begin
      r_dout  <= w_dout_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state;
    end
  end

  assign dout    = r_dout;
  assign sel_out = r_sel;
  assign valid   = r_valid;
  assign wrap    = r_wrap;

endmodule
